// File: rtl/vec_isa_pkg.sv
// Shared ISA definitions for the vector decode sequencer: opcodes, field
// positions, decoded-instruction structs and the beat-count rule.
package vec_isa_pkg;

    localparam logic [3:0] OP_VADD = 4'h0;
    localparam logic [3:0] OP_VDOT = 4'h1;
    localparam logic [3:0] OP_SMUL = 4'h2;
    localparam logic [3:0] OP_SST  = 4'h3;
    localparam logic [3:0] OP_VLD  = 4'h4;
    localparam logic [3:0] OP_VST  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SLH  = 4'h7;
    localparam logic [3:0] OP_NOP  = 4'hF;

    localparam int OP_LSB = 12;
    localparam int FA_LSB = 9;
    localparam int FB_LSB = 6;
    localparam int FC_LSB = 3;
    localparam int REG_W  = 3;
    localparam int OFF_W  = 6;
    localparam int IMM_W  = 8;

    typedef struct packed {
        logic v_we;
        logic s_we;
        logic s_we_last;   // scalar write only on the reduction beat
        logic mem_re;
        logic mem_we;
    } en_mask_t;

    typedef struct packed {
        logic [3:0]       functype;
        logic [REG_W-1:0] dst;
        logic [REG_W-1:0] s1;
        logic [REG_W-1:0] s2;
        logic [OFF_W-1:0] offset;
        logic [IMM_W-1:0] immediate;
        en_mask_t         en;
        logic             illegal;
    } dec_t;

    function automatic int beats_for(logic [3:0] op, int vlen, int lanes);
        case (op)
            OP_VADD, OP_SMUL: return vlen / lanes;
            OP_VDOT:          return vlen / lanes + 1;
            OP_VLD, OP_VST:   return vlen;
            default:          return 1;
        endcase
    endfunction

endpackage

// File: rtl/vec_instr_fields.sv
// Combinational field extractor: maps a raw instruction word to its decoded
// fields, per-beat enable mask, illegal flag and beat count.
module vec_instr_fields
    import vec_isa_pkg::*;
#(
    parameter int VLEN   = 16,
    parameter int LANES  = 4,
    parameter int BEAT_W = $clog2(VLEN + 2)
) (
    input  logic [15:0]       instr,
    output dec_t              dec,
    output logic [BEAT_W-1:0] beats
);

    logic [REG_W-1:0] fa, fb, fc;

    assign fa = instr[FA_LSB +: REG_W];
    assign fb = instr[FB_LSB +: REG_W];
    assign fc = instr[FC_LSB +: REG_W];

    always_comb begin
        dec          = '0;
        dec.functype = instr[OP_LSB +: 4];
        case (dec.functype)
            OP_VADD, OP_SMUL: begin
                dec.dst = fa; dec.s1 = fb; dec.s2 = fc;
                dec.en.v_we = 1'b1;
            end
            OP_VDOT: begin
                dec.dst = fa; dec.s1 = fb; dec.s2 = fc;
                dec.en.s_we_last = 1'b1;
            end
            OP_SST, OP_VST: begin
                dec.s1 = fa; dec.s2 = fb;
                dec.offset = instr[OFF_W-1:0];
                dec.en.mem_we = 1'b1;
            end
            OP_VLD: begin
                dec.dst = fa; dec.s1 = fb;
                dec.offset = instr[OFF_W-1:0];
                dec.en.mem_re = 1'b1;
                dec.en.v_we   = 1'b1;
            end
            OP_SLL, OP_SLH: begin
                dec.dst = fa; dec.s1 = fa;
                dec.immediate = instr[IMM_W-1:0];
                dec.en.s_we = 1'b1;
            end
            OP_NOP: ;
            default: dec.illegal = 1'b1;
        endcase
        beats = BEAT_W'(beats_for(dec.functype, VLEN, LANES));
    end

endmodule

// File: rtl/vec_decode_seq.sv
// Instruction decoder and multi-beat sequencer: latches decoded fields on a
// valid/ready handshake and walks the beat counter, honouring downstream stall.
module vec_decode_seq
    import vec_isa_pkg::*;
#(
    parameter int VLEN   = 16,
    parameter int LANES  = 4,
    parameter int BEAT_W = $clog2(VLEN + 2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    input  logic              stall,
    output logic              op_valid,
    output logic [3:0]        functype,
    output logic [2:0]        dst_addr,
    output logic [2:0]        src1_addr,
    output logic [2:0]        src2_addr,
    output logic [5:0]        offset,
    output logic [7:0]        immediate,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              first_beat,
    output logic              last_beat,
    output logic              v_we,
    output logic              s_we,
    output logic              mem_re,
    output logic              mem_we,
    output logic              illegal
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t            state;
    dec_t              dec_in, cur;
    logic [BEAT_W-1:0] beats_in, beats_q;
    logic              is_last, accept, go;

    vec_instr_fields #(.VLEN(VLEN), .LANES(LANES), .BEAT_W(BEAT_W)) u_fields (
        .instr (instr),
        .dec   (dec_in),
        .beats (beats_in)
    );

    assign op_valid = (state == EXEC);
    assign is_last  = op_valid && (beat_idx == beats_q - BEAT_W'(1));
    // Gated by rst_n so every output reads 0 while reset is held.
    assign instr_ready = rst_n & ((state == IDLE) | (is_last & ~stall));
    assign accept      = instr_valid & instr_ready;
    assign go          = op_valid & ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur      <= '0;
            beats_q  <= '0;
            beat_idx <= '0;
        end else if (accept) begin
            state    <= EXEC;
            cur      <= dec_in;
            beats_q  <= beats_in;
            beat_idx <= '0;
        end else if (go) begin
            if (is_last) state <= IDLE;
            else         beat_idx <= beat_idx + BEAT_W'(1);
        end
    end

    assign functype   = cur.functype;
    assign dst_addr   = cur.dst;
    assign src1_addr  = cur.s1;
    assign src2_addr  = cur.s2;
    assign offset     = cur.offset;
    assign immediate  = cur.immediate;
    assign first_beat = op_valid && (beat_idx == '0);
    assign last_beat  = is_last;
    assign v_we       = go & cur.en.v_we;
    assign s_we       = go & (cur.en.s_we | (cur.en.s_we_last & is_last));
    assign mem_re     = go & cur.en.mem_re;
    assign mem_we     = go & cur.en.mem_we;
    assign illegal    = op_valid & cur.illegal;

endmodule

// File: doc/vec_decode_seq.md
Name: vec_decode_seq

Overview:
Parametrised successor to the single-cycle instruction decoder. It accepts 16-bit instructions over a valid/ready handshake, registers the decoded fields, and sequences multi-beat vector operations with a beat counter and per-beat enables. A downstream stall can hold it. It sits between fetch and the vector/scalar register files and the data-memory port.

Parameters:
VLEN, 16, elements per vector; power of two, at least 2.
LANES, 4, elements processed per arithmetic beat; power of two, divides VLEN.
BEAT_W, $clog2(VLEN+2), width of the beat counter and index.

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
instr_valid  in  1  fetch presents instr
instr  in  16  instruction word
instr_ready  out  1  decoder accepts instr this cycle
stall  in  1  downstream hold; freezes the sequencer
op_valid  out  1  registered fields and enables are valid this cycle
functype  out  4  latched opcode, instr[15:12]
dst_addr  out  3  destination register
src1_addr  out  3  source 1 / base register
src2_addr  out  3  source 2
offset  out  6  memory offset
immediate  out  8  scalar load immediate
beat_idx  out  BEAT_W  current beat, 0..beats-1
first_beat  out  1  beat_idx==0 and op_valid
last_beat  out  1  beat_idx==beats-1 and op_valid
v_we  out  1  vector register write this beat
s_we  out  1  scalar register write this beat
mem_re  out  1  memory read this beat
mem_we  out  1  memory write this beat
illegal  out  1  latched opcode is undefined

Behaviour:
- Reset (asynchronous, rst_n=0): the FSM goes to IDLE and every output is 0 except instr_ready, which is 1 after reset is released. All internal registers are cleared. Reset mid-operation abandons the operation and issues no further enables.
- FSM states: IDLE and EXEC.
- IDLE: instr_ready=1. A handshake (instr_valid & instr_ready) latches the fields, clears beat_idx to 0, loads beats, and moves to EXEC next cycle.
- EXEC: op_valid=1.
  - stall=1: all outputs and state hold.
  - stall=0 and not last beat: beat_idx increments.
  - stall=0 and last beat: instr_ready=1. If instr_valid=1, the next instruction loads with no bubble. Otherwise the FSM returns to IDLE.
- instr_ready is combinational: IDLE | (EXEC & last_beat & ~stall). It never depends on instr_valid.
- Decode and beat count per opcode:
  - VADD 0000: dst[11:9], s1[8:6], s2[5:3]. VLEN/LANES beats. v_we every beat.
  - VDOT 0001: same fields. VLEN/LANES+1 beats (the final beat is the reduction). s_we on the last beat only.
  - SMUL 0010: dst[11:9], vector s1[8:6], scalar s2[5:3]. VLEN/LANES beats. v_we every beat.
  - SST 0011: s1[11:9] is the data register, s2[8:6] is the base, offset[5:0]. 1 beat. mem_we.
  - VLD 0100: dst[11:9], s1[8:6] is the base, offset[5:0]. VLEN beats. mem_re and v_we every beat.
  - VST 0101: s1[11:9] is the data register, s2[8:6] is the base, offset[5:0]. VLEN beats. mem_we every beat.
  - SLL 0110 / SLH 0111: dst=s1=[11:9], immediate[7:0]. 1 beat. s_we.
  - NOP 1111: 1 beat, no enables.
  - Opcodes 1000-1110: handled as NOP with illegal=1 for their beat.
- Unused field outputs are 0.
- Enables are gated by op_valid & ~stall, so they are 0 during a stall cycle.
- Arithmetic: beat_idx is unsigned and never wraps. Beats equal to 1 makes first_beat and last_beat coincide.

Decomposition:
- Shared package vec_isa_pkg holds:
  - the opcode localparams;
  - field bit-position constants;
  - the beat-count function beats_for(op, VLEN, LANES).
- One sub-module, vec_instr_fields: a combinational field extractor that maps instr to {dst, s1, s2, offset, immediate, enable mask, illegal, beats}. It is instantiated once, ahead of the latch.

Test Plan:
1. Reset, then VADD 0x0A98 with VLEN=16, LANES=4 -> op_valid for 4 cycles; dst=5, s1=2, s2=3; v_we=1 on beats 0-3; last_beat on beat 3; instr_ready=1 in that last cycle.
2. VLD 0x4A45 followed by SLL 0x6C7F held valid -> 16 VLD beats with mem_re=v_we=1 and offset=5; SLL is accepted on beat 15 with no bubble; next cycle dst=6, immediate=0x7F, s_we=1.
3. VDOT 0x1298 -> 5 beats; s_we=1 only on beat 4; v_we=0 throughout.
4. stall=1 for 3 cycles during VST beat 7 -> beat_idx holds at 7; mem_we=0 while stalled; the operation completes 3 cycles late with 16 mem_we pulses in total.
5. Opcode 0x9xxx -> 1 beat with illegal=1 and all enables 0; NOP 0xF000 -> 1 beat with illegal=0.
6. rst_n low asynchronously mid-VLD (beat 9) -> all outputs 0 immediately; after release, IDLE with instr_ready=1 and no residual enables.
